// File: rtl/sd_bd_ring.sv
// sd_bd_ring -- buffer-descriptor ring store, responder side of the data
// master's BD read handshake.
//
// Host writes each BD as two 32-bit words (word0 = system address,
// word1 = card block argument). The master reads the oldest pending BD over
// re_s/ack_o_s and retires it with a_cmp. free_bd reports free slots.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   we_m, dat_in_m  host write strobe / data (one word per cycle)
//   new_bd          one-cycle pulse after a BD's word1 is committed
//   wr_err          sticky: write attempted while full
//   re_s            master read request (level)
//   ack_o_s         read data valid pulse, never on consecutive cycles
//   dat_out_s       read data, held between acks
//   a_cmp           retire the oldest BD
//   cmp_err         sticky: retire with nothing pending
//   bd_clr          synchronous flush, highest priority
//   free_bd         free entries, 0..BD_DEPTH
//
// Build option: define SD_BD_RD_16BIT_EN for a 16-bit read port; each BD is
// then read as four half-words (word0 lo, word0 hi, word1 lo, word1 hi).
module sd_bd_ring #(
    parameter int BD_DEPTH = 8,
    parameter int PTR_W    = 3,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_m,
    input  logic [31:0]      dat_in_m,
    output logic             new_bd,
    output logic             wr_err,
    input  logic             re_s,
    output logic             ack_o_s,
`ifdef SD_BD_RD_16BIT_EN
    output logic [15:0]      dat_out_s,
`else
    output logic [31:0]      dat_out_s,
`endif
    input  logic             a_cmp,
    output logic             cmp_err,
    input  logic             bd_clr,
    output logic [CNT_W-1:0] free_bd
);

`ifdef SD_BD_RD_16BIT_EN
    localparam int SEL_W = 2;
`else
    localparam int SEL_W = 1;
`endif

    // Entry e, word w lives at index {e, w}.
    logic [31:0]      mem [2*BD_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             wr_half;
    logic [SEL_W-1:0] rd_sel;
    logic [31:0]      rd_word;

    logic pending, full, wr_word, commit, retire, rd_fire;

    assign pending = (free_bd != CNT_W'(BD_DEPTH));
    assign full    = (free_bd == '0);
    // Fullness is only checked on word0, so an accepted word0 guarantees
    // room for its word1.
    assign wr_word = we_m && !bd_clr && (wr_half || !full);
    assign commit  = wr_word && wr_half;
    assign retire  = a_cmp && !bd_clr && pending;
    assign rd_fire = re_s && pending && !ack_o_s && !bd_clr;

    assign rd_word = mem[{rd_ptr, rd_sel[SEL_W-1]}];

    always_ff @(posedge clk) begin
        if (wr_word)
            mem[{wr_ptr, wr_half}] <= dat_in_m;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_half   <= 1'b0;
            rd_sel    <= '0;
            free_bd   <= CNT_W'(BD_DEPTH);
            new_bd    <= 1'b0;
            wr_err    <= 1'b0;
            cmp_err   <= 1'b0;
            ack_o_s   <= 1'b0;
            dat_out_s <= '0;
        end else if (bd_clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            wr_half <= 1'b0;
            rd_sel  <= '0;
            free_bd <= CNT_W'(BD_DEPTH);
            new_bd  <= 1'b0;
            wr_err  <= 1'b0;
            cmp_err <= 1'b0;
            ack_o_s <= 1'b0;
        end else begin
            // write side
            new_bd <= commit;
            if (we_m && !wr_half && full)
                wr_err <= 1'b1;
            if (wr_word)
                wr_half <= !wr_half;
            if (commit)
                wr_ptr <= wr_ptr + 1'b1;

            // occupancy: a commit and a retire in one cycle cancel out
            case ({commit, retire})
                2'b10:   free_bd <= free_bd - 1'b1;
                2'b01:   free_bd <= free_bd + 1'b1;
                default: free_bd <= free_bd;
            endcase

            // read side
            ack_o_s <= rd_fire;
            if (rd_fire) begin
`ifdef SD_BD_RD_16BIT_EN
                dat_out_s <= rd_sel[0] ? rd_word[31:16] : rd_word[15:0];
`else
                dat_out_s <= rd_word;
`endif
            end

            // retire
            if (a_cmp && !pending)
                cmp_err <= 1'b1;
            if (retire)
                rd_ptr <= rd_ptr + 1'b1;

            // rd_sel: restart on retire or dropped request, saturate on last word
            if (retire || !re_s)
                rd_sel <= '0;
            else if (rd_fire && (rd_sel != {SEL_W{1'b1}}))
                rd_sel <= rd_sel + 1'b1;
        end
    end

endmodule

// File: doc/sd_bd_ring.md
Name: sd_bd_ring

Overview:
- Buffer-descriptor (BD) store: the responder side of the data master's BD read handshake.
- Host software writes BDs as word pairs (word0 = system address, word1 = card block argument) into a circular store.
- The data master fetches the oldest pending BD over the re/ack port and retires it with a completion pulse.
- One instance serves TX BDs and one serves RX BDs. Each reports its free-slot count so the master can detect pending work (free_bd != BD_DEPTH).

Parameters:
- BD_DEPTH, 8, number of BD entries; power of 2, minimum 2.
- PTR_W, 3, log2(BD_DEPTH).
- CNT_W, 4, PTR_W+1; width of free_bd.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- we_m  in  1  host write strobe, one word per cycle
- dat_in_m  in  32  host write data
- new_bd  out  1  one-cycle pulse when a complete BD is committed
- wr_err  out  1  sticky: write attempted while full; cleared by bd_clr or rst
- re_s  in  1  master read request, level
- ack_o_s  out  1  read data valid pulse
- dat_out_s  out  32  read data (16 with SD_BD_RD_16BIT_EN)
- a_cmp  in  1  master retire pulse for the oldest BD
- cmp_err  out  1  sticky: a_cmp received with no pending BD
- bd_clr  in  1  synchronous flush
- free_bd  out  CNT_W  free entries, range 0..BD_DEPTH

Behaviour:
- Reset:
  - free_bd=BD_DEPTH.
  - new_bd, ack_o_s, wr_err and cmp_err all 0.
  - dat_out_s=0.
  - wr_ptr, rd_ptr, wr_half and rd_sel all 0.
- Write side:
  - wr_half selects the word slot. The we_m with wr_half=0 stores word0 and sets wr_half=1.
  - The next we_m stores word1, clears wr_half, advances wr_ptr (mod BD_DEPTH), decrements free_bd, and pulses new_bd the following cycle.
  - we_m while free_bd==0 and wr_half==0: data dropped, wr_err<=1, pointers unchanged.
  - Because free_bd>0 is checked on word0, word1 never overflows.
- Read side, 32-bit:
  - Pending = BD_DEPTH-free_bd.
  - re_s=1, pending>0 and ack_o_s=0 in cycle N: in cycle N+1, ack_o_s=1 and dat_out_s=entry[rd_ptr].word[rd_sel]; rd_sel then advances.
  - ack_o_s is never high on two consecutive cycles (min one idle cycle between acks).
  - rd_sel saturates after the last word: further requests re-return the last word.
  - re_s=0 resets rd_sel to 0 at the next edge, so every burst starts at word0.
  - re_s with pending==0: no ack, ever.
  - dat_out_s holds its last value when ack_o_s=0.
- Retire:
  - a_cmp with pending>0: rd_ptr advances, free_bd increments, rd_sel=0.
  - a_cmp with pending==0: ignored, cmp_err<=1.
  - Reading alone never frees a slot. A BD may be re-read any number of times before a_cmp.
- Simultaneous events:
  - word1 commit and a_cmp in the same cycle: free_bd unchanged, both pointers advance.
  - Commit with free_bd==0 cannot occur.
- Flush:
  - bd_clr has priority over all other inputs.
  - It resets the pointers, wr_half and rd_sel; sets free_bd=BD_DEPTH; clears wr_err and cmp_err; sets ack_o_s=0.
  - A half-written BD is discarded.
- Wrap-around: both pointers wrap mod BD_DEPTH; entry index BD_DEPTH-1 is followed by 0.
- Reset mid-burst: all state returns to reset values immediately; an in-flight ack is lost.
- Storage: 2*BD_DEPTH x 32 registers or inferred RAM; read is synchronous, registered into dat_out_s.

Optional Feature:
- Macro: SD_BD_RD_16BIT_EN.
- Defined:
  - dat_out_s is 16 bits; a BD is read as 4 acks in the order word0[15:0], word0[31:16], word1[15:0], word1[31:16].
  - rd_sel is 2 bits and saturates at 3.
- Undefined: dat_out_s is 32 bits; a BD is read as 2 acks; rd_sel is 1 bit.
- The write side is identical in both builds.

Test Plan:
- Reset, then write 0x0000_1000 and 0x0000_0200 -> new_bd pulses once, free_bd 8->7. Hold re_s -> acks return 0x1000 then 0x200 on non-consecutive cycles; drop re_s; a_cmp -> free_bd=8.
- Write 8 BDs, then a 9th word0 -> free_bd=0, wr_err=1, no new_bd. a_cmp, then write a BD -> accepted into entry 0 (wrap); a read after 7 more a_cmp returns it.
- re_s=1 with free_bd=8 for 20 cycles -> ack_o_s stays 0. a_cmp with free_bd=8 -> cmp_err=1, free_bd stays 8.
- One BD pending; word1 commit of a second BD in the same cycle as a_cmp -> free_bd stays 7; the next read returns the second BD.
- Write word0 only, assert bd_clr -> free_bd=8, wr_half=0; the next two writes form a fresh BD.
- SD_BD_RD_16BIT_EN build, BD 0xAAAA5555/0x12343456 -> acks return 0x5555, 0xAAAA, 0x3456, 0x1234.
